dmem_access_ctrl: RTL and testbench

Sequences the single-port, word-addressed data memory (256 x 32, async read, sync write) and shares it between two requesters: port 0 (pipeline MEM stage) and port 1 (program loader/debug). Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. Sub-word stores use a read-modify-write. Misaligned or out-of-range requests are reported as errors.

---
 rtl/dmem_access_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: arbitrates two requesters onto a single-port
// 32-bit word memory, with byte/half extraction on loads and read-modify-write stores.
module dmem_access_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rq0_valid,
    output logic              rq0_ready,
    input  logic              rq0_we,
    input  logic [1:0]        rq0_size,
    input  logic              rq0_uns,
    input  logic [31:0]       rq0_addr,
    input  logic [31:0]       rq0_wdata,
    input  logic              rq1_valid,
    output logic              rq1_ready,
    input  logic              rq1_we,
    input  logic [1:0]        rq1_size,
    input  logic              rq1_uns,
    input  logic [31:0]       rq1_addr,
    input  logic [31:0]       rq1_wdata,
    output logic              rs0_valid,
    output logic              rs1_valid,
    output logic [31:0]       rs_rdata,
    output logic              rs_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    // state  | meaning
    // IDLE   | arbitrate and accept one request
    // ACCESS | address memory; load extract, word write, or sub-word merge
    // WRITE  | write back merged word of a sub-word store
    // RESP   | one-cycle response pulse to the owner
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d, uns_q, uns_d, owner_q, owner_d, last_q, last_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d, merged_q, merged_d;
    logic        grant0, grant1, req_err, mem_we_raw;
    logic [4:0]  bsh, hsh;
    logic [31:0] rd_shift, load_val, merge_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            merged_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            uns_q    <= uns_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            merged_q <= merged_d;
        end
    end

    // last_q records the port granted most recently; it breaks ties toward the other one
    assign grant0 = rq0_valid & (~rq1_valid | last_q);
    assign grant1 = rq1_valid & (~rq0_valid | ~last_q);

    always_comb begin
        req_err = (size_q == 2'b11)
                | ((size_q == 2'b01) & addr_q[0])
                | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00))
                | (addr_q[31:ADDR_W+2] != '0);
        bsh      = {addr_q[1:0], 3'b000};
        hsh      = {addr_q[1], 4'b0000};
        rd_shift = mem_rdata >> (size_q[0] ? hsh : bsh);
        case (size_q)
            2'b00:   load_val = uns_q ? {24'b0, rd_shift[7:0]}
                                      : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = uns_q ? {16'b0, rd_shift[15:0]}
                                      : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = mem_rdata;
        endcase
        merge_val = mem_rdata;
        if (size_q[0]) merge_val[hsh +: 16] = wdata_q[15:0];
        else           merge_val[bsh +: 8]  = wdata_q[7:0];
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        uns_d    = uns_q;
        owner_d  = owner_q;
        last_d   = last_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        merged_d = merged_q;
        case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    owner_d = grant1;
                    last_d  = grant1;
                    we_d    = grant1 ? rq1_we    : rq0_we;
                    size_d  = grant1 ? rq1_size  : rq0_size;
                    uns_d   = grant1 ? rq1_uns   : rq0_uns;
                    addr_d  = grant1 ? rq1_addr  : rq0_addr;
                    wdata_d = grant1 ? rq1_wdata : rq0_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = '0;
                if (req_err) begin
                    state_d = RESP;
                end else if (!we_q) begin
                    rdata_d = load_val;
                    state_d = RESP;
                end else if (size_q == 2'b10) begin
                    state_d = RESP;
                end else begin
                    merged_d = merge_val;
                    state_d  = WRITE;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rq0_ready  = 1'b0;
        rq1_ready  = 1'b0;
        rs0_valid  = 1'b0;
        rs1_valid  = 1'b0;
        rs_err     = 1'b0;
        mem_we_raw = 1'b0;
        mem_wdata  = '0;
        case (state_q)
            IDLE: begin
                rq0_ready = grant0;
                rq1_ready = grant1;
            end
            ACCESS: begin
                if (!req_err && we_q && (size_q == 2'b10)) begin
                    mem_we_raw = 1'b1;
                    mem_wdata  = wdata_q;
                end
            end
            WRITE: begin
                mem_we_raw = 1'b1;
                mem_wdata  = merged_q;
            end
            RESP: begin
                rs0_valid = ~owner_q;
                rs1_valid = owner_q;
                rs_err    = req_err;
            end
            default: ;
        endcase
    end

    // rst_n gating makes a reset asserted mid-cycle cancel any pending write
    assign mem_we   = mem_we_raw & rst_n;
    assign mem_addr = addr_q[ADDR_W+1:2];
    assign rs_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus random two-port traffic
// compared every cycle against a transaction-level reference model.
module tb_dmem_access_ctrl;
    localparam int ADDR_W = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic rq0_valid = 1'b0, rq0_we = 1'b0, rq0_uns = 1'b0;
    logic rq1_valid = 1'b0, rq1_we = 1'b0, rq1_uns = 1'b0;
    logic [1:0] rq0_size = 2'b0, rq1_size = 2'b0;
    logic [31:0] rq0_addr = '0, rq0_wdata = '0, rq1_addr = '0, rq1_wdata = '0;
    logic rq0_ready, rq1_ready, rs0_valid, rs1_valid, rs_err, mem_we;
    logic [31:0] rs_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    logic [31:0] tb_mem  [256] = '{default: 32'h0};
    logic [31:0] ref_mem [256] = '{default: 32'h0};

    dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_we(rq0_we), .rq0_size(rq0_size),
        .rq0_uns(rq0_uns), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_we(rq1_we), .rq1_size(rq1_size),
        .rq1_uns(rq1_uns), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rs0_valid(rs0_valid), .rs1_valid(rs1_valid), .rs_rdata(rs_rdata), .rs_err(rs_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    assign mem_rdata = tb_mem[mem_addr];

    int n_checks = 0, n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'b0, act}, {31'b0, exp});
    endtask

    function automatic bit f_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
               || (a >= (32'd4 << ADDR_W));
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [31:0] a);
        logic [31:0] v;
        if (sz == 2'd2) return w;
        if (sz == 2'd0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [1:0] sz,
                                            input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] m;
        int sh;
        if (sz == 2'd2) return wd;
        if (sz == 2'd0) begin sh = 8 * int'(a % 4);        m = 32'hFF   << sh; end
        else            begin sh = 16 * int'((a / 2) % 2); m = 32'hFFFF << sh; end
        return (old & ~m) | ((wd << sh) & m);
    endfunction

    // reference model: at most one transaction in flight
    bit chk_en = 0, pend = 0, acc0 = 0, acc1 = 0;
    int p_owner, p_resp, p_wcyc, m_last = 1;
    bit p_err;
    logic [1:0] p_size;
    logic [31:0] p_rdata, p_addr, p_wdata;
    int we_cnt = 0, rsp_cnt = 0, rsp_cyc = 0, acc_cyc = 0, rsp_port = 0;
    logic [31:0] rsp_data = '0;
    logic rsp_err = 1'b0;
    int grants[$];
    bit er0, er1, ev0, ev1, ewe;
    logic [31:0] nv;
    logic [ADDR_W-1:0] widx;

    always @(negedge clk) begin
        acc0 = rq0_valid && rq0_ready;
        acc1 = rq1_valid && rq1_ready;
        if (mem_we) we_cnt++;
        if (rs0_valid || rs1_valid) begin
            rsp_cnt++;
            rsp_cyc  = cyc;
            rsp_port = rs1_valid ? 1 : 0;
            rsp_data = rs_rdata;
            rsp_err  = rs_err;
        end
        if (chk_en) begin
            er0 = 0; er1 = 0;
            if (!pend && rst_n) begin
                if (rq0_valid && (!rq1_valid || m_last == 1)) er0 = 1;
                else if (rq1_valid) er1 = 1;
            end
            chk1("rq0_ready", rq0_ready, er0);
            chk1("rq1_ready", rq1_ready, er1);
            ev0 = pend && rst_n && cyc == p_resp && p_owner == 0;
            ev1 = pend && rst_n && cyc == p_resp && p_owner == 1;
            chk1("rs0_valid", rs0_valid, ev0);
            chk1("rs1_valid", rs1_valid, ev1);
            if (ev0 || ev1) begin
                chk1("rs_err", rs_err, p_err);
                chk32("rs_rdata", rs_rdata, p_rdata);
            end
            ewe = pend && rst_n && !p_err && cyc == p_wcyc;
            chk1("mem_we", mem_we, ewe);
            if (ewe) begin
                widx = p_addr[ADDR_W+1:2];
                nv = f_merge(ref_mem[widx], p_size, p_addr, p_wdata);
                chk32("mem_addr", 32'(mem_addr), 32'(widx));
                chk32("mem_wdata", mem_wdata, nv);
                ref_mem[widx] = nv;
            end
            if (!rst_n) begin pend = 0; m_last = 1; end
            else if (ev0 || ev1) pend = 0;
            if (er0 || er1) begin
                pend    = 1;
                p_owner = er1 ? 1 : 0;
                m_last  = p_owner;
                p_size  = er1 ? rq1_size  : rq0_size;
                p_addr  = er1 ? rq1_addr  : rq0_addr;
                p_wdata = er1 ? rq1_wdata : rq0_wdata;
                p_err   = f_err(p_size, p_addr);
                if (er1 ? rq1_we : rq0_we) begin
                    p_rdata = '0;
                    p_wcyc  = p_err ? -1 : ((p_size == 2'd2) ? cyc + 1 : cyc + 2);
                    p_resp  = (!p_err && p_size != 2'd2) ? cyc + 3 : cyc + 2;
                end else begin
                    p_wcyc  = -1;
                    p_resp  = cyc + 2;
                    p_rdata = p_err ? 32'h0 : f_load(ref_mem[p_addr[ADDR_W+1:2]], p_size,
                                                      er1 ? rq1_uns : rq0_uns, p_addr);
                end
                acc_cyc = cyc;
                grants.push_back(p_owner);
            end
        end
    end

    task automatic set_port(input int p, input logic v, input logic we, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            rq0_valid = v; rq0_we = we; rq0_size = sz; rq0_uns = uns; rq0_addr = a; rq0_wdata = wd;
        end else begin
            rq1_valid = v; rq1_we = we; rq1_size = sz; rq1_uns = uns; rq1_addr = a; rq1_wdata = wd;
        end
    endtask

    task automatic wait_acc(input int p);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (p == 0 ? acc0 : acc1) break;
        end
        chk1("accept_timeout", k < 20, 1'b1);
    endtask

    task automatic do_req(input int p, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        int n0;
        n0 = rsp_cnt;
        @(posedge clk); #1;
        set_port(p, 1'b1, we, sz, uns, a, wd);
        wait_acc(p);
        @(posedge clk); #1;
        if (p == 0) rq0_valid = 1'b0; else rq1_valid = 1'b0;
        for (int i = 0; i < 10 && rsp_cnt == n0; i++) begin @(negedge clk); #1; end
        chk32("rsp_count", 32'(rsp_cnt - n0), 32'd1);
    endtask

    task automatic rand_port(input int p);
        logic [1:0] sz;
        logic [31:0] a;
        bit v, ac;
        v  = (p == 0) ? rq0_valid : rq1_valid;
        ac = (p == 0) ? acc0 : acc1;
        if (!v || ac) begin
            sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            a  = 4 * ($urandom % 8);
            if ($urandom % 4 == 0) a = a + ($urandom % 4);
            else if (sz == 2'd1) a = a + 2 * ($urandom % 2);
            if ($urandom % 16 == 0) a = a | (32'h400 << ($urandom % 22));
            set_port(p, ($urandom % 3) != 0, 1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom);
        end else if ($urandom % 8 == 0) begin
            if (p == 0) rq0_valid = 1'b0; else rq1_valid = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, n0;
        logic [1:0] esz [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
        logic [31:0] ead [4] = '{32'h11, 32'h13, 32'h10, 32'h400};
        logic ewe_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_rs0", rs0_valid, 1'b0);
        chk1("reset_rs1", rs1_valid, 1'b0);
        chk1("reset_err", rs_err, 1'b0);
        chk1("reset_we", mem_we, 1'b0);
        chk32("reset_rdata", rs_rdata, 32'h0);
        chk32("reset_maddr", 32'(mem_addr), 32'h0);
        chk32("reset_wdata", mem_wdata, 32'h0);
        rst_n  = 1'b1;
        chk_en = 1;

        // word path
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        chk32("sw_latency", 32'(rsp_cyc - acc_cyc), 32'd2);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk32("lw_latency", 32'(rsp_cyc - acc_cyc), 32'd2);
        chk32("lw_data", rsp_data, 32'hDEADBEEF);
        chk1("lw_err", rsp_err, 1'b0);
        chk32("sw_mem4", tb_mem[4], 32'hDEADBEEF);

        // read-modify-write
        w0 = we_cnt;
        do_req(0, 1'b1, 2'd0, 1'b0, 32'h12, 32'h55);
        chk32("sb_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
        chk32("sb_we_pulses", 32'(we_cnt - w0), 32'd1);
        chk32("sb_mem4", tb_mem[4], 32'hDE55BEEF);
        do_req(0, 1'b1, 2'd1, 1'b0, 32'h10, 32'h1234);
        chk32("sh_mem4", tb_mem[4], 32'hDE551234);
        do_req(0, 1'b1, 2'd1, 1'b0, 32'h10, 32'hABCDF0EF);
        chk32("sh2_mem4", tb_mem[4], 32'hDE55F0EF);

        // load extension
        do_req(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        chk32("lb_data", rsp_data, 32'hFFFFFFF0);
        do_req(1, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        chk32("lbu_data", rsp_data, 32'h000000F0);
        chk32("lbu_port", 32'(rsp_port), 32'd1);
        do_req(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        chk32("lh_data", rsp_data, 32'hFFFFDE55);
        do_req(0, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        chk32("lhu_data", rsp_data, 32'h0000DE55);

        // errors
        w0 = we_cnt;
        for (int i = 0; i < 4; i++) begin
            do_req(0, ewe_t[i], esz[i], 1'b0, ead[i], 32'h12345678);
            chk1("err_flag", rsp_err, 1'b1);
            chk32("err_rdata", rsp_data, 32'h0);
            chk32("err_latency", 32'(rsp_cyc - acc_cyc), 32'd2);
        end
        chk32("err_no_we", 32'(we_cnt - w0), 32'd0);
        chk32("err_mem4", tb_mem[4], 32'hDE55F0EF);

        // reset during the WRITE cycle of a byte store
        n0 = rsp_cnt;
        w0 = we_cnt;
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h11, 32'hAA);
        wait_acc(0);
        @(posedge clk); #1;
        rq0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk1("mid_rst_rs0", rs0_valid, 1'b0);
        chk1("mid_rst_rs1", rs1_valid, 1'b0);
        chk1("mid_rst_err", rs_err, 1'b0);
        chk1("mid_rst_we", mem_we, 1'b0);
        chk32("mid_rst_rdata", rs_rdata, 32'h0);
        chk32("mid_rst_maddr", 32'(mem_addr), 32'h0);
        chk32("mid_rst_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk32("mid_rst_mem4", tb_mem[4], 32'hDE55F0EF);
        chk32("mid_rst_no_rsp", 32'(rsp_cnt - n0), 32'd0);
        chk32("mid_rst_no_we", 32'(we_cnt - w0), 32'd0);

        // both ports continuously valid
        grants.delete();
        set_port(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        for (int i = 0; i < 60 && grants.size() < 4; i++) @(posedge clk);
        #1;
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
        repeat (6) @(posedge clk);
        chk32("arb_count", 32'(grants.size()), 32'd4);
        if (grants.size() >= 4) begin
            chk32("arb_g0", 32'(grants[0]), 32'd0);
            chk32("arb_g1", 32'(grants[1]), 32'd1);
            chk32("arb_g2", 32'(grants[2]), 32'd0);
            chk32("arb_g3", 32'(grants[3]), 32'd1);
        end

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rand_port(0);
            rand_port(1);
        end
        @(posedge clk); #1;
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) chk32("final_mem", tb_mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
